// File: rtl/kernel_host.sv
// -----------------------------------------------------------------------------
// kernel_host
//
// Host-side driver for a synthesized kernel that uses the
// clk / r_enable / init_i / w_enable / result handshake.
//
// Arguments arrive on a valid/ready stream. Each accepted argument launches one
// kernel job: the argument is driven on kern_init_i and a one-cycle
// kern_r_enable pulse starts the kernel. The block then waits for the kernel's
// sticky done flag (kern_w_enable), captures kern_result and pushes it into a
// small result FIFO. A watchdog abandons a job that never finishes and pushes
// a flagged timeout entry (data 0) in its place.
//
// Handshake rule (both streams): a transfer happens on a rising clk edge where
// valid and ready are both 1. arg_ready does not depend on arg_valid, and
// res_valid does not depend on res_ready. An entry is popped when
// res_valid & res_ready.
//
// Ports
//   clk            in   1       clock, all logic on posedge
//   r_enable       in   1       synchronous active-high reset (also re-inits the kernel)
//   arg_valid      in   1       argument available
//   arg_ready      out  1       argument accepted this cycle (IDLE only)
//   arg_data       in   DATA_W  argument, becomes kern_init_i
//   kern_r_enable  out  1       kernel start/load pulse (held high during reset)
//   kern_init_i    out  DATA_W  latched argument for the kernel
//   kern_w_enable  in   1       kernel done, sticky until the next kern_r_enable
//   kern_result    in   DATA_W  kernel result, valid while kern_w_enable=1
//   res_valid      out  1       result FIFO non-empty
//   res_ready      in   1       consumer takes the head entry
//   res_data       out  DATA_W  head entry data (0 for timeout entries)
//   res_timeout    out  1       head entry is a timeout
//   busy           out  1       a job is in flight (state != IDLE)
//   job_count      out  CNT_W   entries pushed since reset, wrapping
//   dbg_state      out  2       FSM state: 0=IDLE 1=ISSUE 2=GUARD 3=WAIT
// -----------------------------------------------------------------------------
module kernel_host #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              r_enable,
    input  logic              arg_valid,
    output logic              arg_ready,
    input  logic [DATA_W-1:0] arg_data,
    output logic              kern_r_enable,
    output logic [DATA_W-1:0] kern_init_i,
    input  logic              kern_w_enable,
    input  logic [DATA_W-1:0] kern_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_timeout,
    output logic              busy,
    output logic [CNT_W-1:0]  job_count,
    output logic [1:0]        dbg_state
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCNT_W = PTR_W + 1;
    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GUARD = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic [DATA_W-1:0]   init_q, init_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0]    jobs_q, jobs_d;

    // FIFO storage is not reset; head outputs are don't-care while empty.
    logic [DATA_W-1:0]   data_mem [DEPTH];
    logic                tout_mem [DEPTH];

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic              accept;
    logic              pop;
    logic              push;
    logic              push_tout;
    logic              push_ok;
    logic [DATA_W-1:0] push_data;

    assign arg_ready     = (state_q == S_IDLE) && !r_enable;
    assign accept        = arg_valid && arg_ready;
    assign res_valid     = (fcnt_q != '0) && !r_enable;
    assign pop           = res_valid && res_ready;
    // A full FIFO can still take an entry when its head leaves in the same cycle.
    assign push_ok       = (fcnt_q != FIFO_FULL) || pop;
    assign push_data     = push_tout ? '0 : kern_result;

    assign kern_r_enable = r_enable || (state_q == S_ISSUE);
    assign kern_init_i   = init_q;
    assign busy          = (state_q != S_IDLE) && !r_enable;
    assign job_count     = jobs_q;
    assign dbg_state     = state_q;
    assign res_data      = data_mem[rd_ptr_q];
    assign res_timeout   = tout_mem[rd_ptr_q];

    // Next-state logic of the job FSM.
    always_comb begin
        state_d   = state_q;
        wdog_d    = wdog_q;
        init_d    = init_q;
        push      = 1'b0;
        push_tout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    init_d  = arg_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_GUARD;
            end
            S_GUARD: begin
                // The previous job's done flag may still be visible here; it
                // is deliberately not looked at in this cycle.
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (kern_w_enable) begin
                    // Done wins over timeout. Without room, hold here with the
                    // watchdog frozen; the kernel keeps its result stable.
                    if (push_ok) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (wdog_q == WD_LAST) begin
                    // Watchdog saturates at its last value until room appears.
                    if (push_ok) begin
                        push      = 1'b1;
                        push_tout = 1'b1;
                        state_d   = S_IDLE;
                    end
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointer / occupancy and job counter next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        jobs_d   = jobs_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            jobs_d   = jobs_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            fcnt_d = fcnt_q + 1'b1;
        end else if (pop && !push) begin
            fcnt_d = fcnt_q - 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_enable) begin
            state_q  <= S_IDLE;
            wdog_q   <= '0;
            init_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            jobs_q   <= '0;
        end else begin
            state_q  <= state_d;
            wdog_q   <= wdog_d;
            init_q   <= init_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            jobs_q   <= jobs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !r_enable) begin
            data_mem[wr_ptr_q] <= push_data;
            tout_mem[wr_ptr_q] <= push_tout;
        end
    end

endmodule

// File: tb/tb_kernel_host.sv
// -----------------------------------------------------------------------------
// tb_kernel_host
//
// Directed-then-randomized bench for kernel_host (DEPTH=4, TIMEOUT=16,
// CNT_W=4 so the job counter wrap is reachable). A behavioural kernel model
// samples kern_r_enable on posedge and drives done/result 1 time unit later;
// it returns arg+1 after a programmable latency, can keep a stale done flag
// visible through the GUARD cycle, or can hang forever. Expected results are
// queued per launched job in exp_q and compared as entries are popped.
// -----------------------------------------------------------------------------
module tb_kernel_host;

    localparam int DATA_W  = 64;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 4;

    // -------------------------------------------------------------------------
    // Clock / reset and DUT
    // -------------------------------------------------------------------------
    logic              clk;
    logic              r_enable;
    logic              arg_valid;
    logic              arg_ready;
    logic [DATA_W-1:0] arg_data;
    logic              kern_r_enable;
    logic [DATA_W-1:0] kern_init_i;
    logic              kern_w_enable;
    logic [DATA_W-1:0] kern_result;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_timeout;
    logic              busy;
    logic [CNT_W-1:0]  job_count;
    logic [1:0]        dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    kernel_host #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .r_enable     (r_enable),
        .arg_valid    (arg_valid),
        .arg_ready    (arg_ready),
        .arg_data     (arg_data),
        .kern_r_enable(kern_r_enable),
        .kern_init_i  (kern_init_i),
        .kern_w_enable(kern_w_enable),
        .kern_result  (kern_result),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_timeout  (res_timeout),
        .busy         (busy),
        .job_count    (job_count),
        .dbg_state    (dbg_state)
    );

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, observed=running expected=finished");
        $fatal(1, "global time limit");
    end

    // -------------------------------------------------------------------------
    // Kernel model
    // -------------------------------------------------------------------------
    int          k_lat;
    bit          k_never;
    bit          k_stale_mode;
    bit          k_stale;
    int          k_cnt;
    int          k_pulses;
    logic [63:0] k_arg;

    initial begin
        logic kr;
        kern_w_enable = 1'b0;
        kern_result   = '0;
        k_lat = 3; k_never = 0; k_stale_mode = 0; k_stale = 0;
        k_cnt = 0; k_pulses = 0; k_arg = '0;
        forever begin
            @(posedge clk);
            kr = kern_r_enable;
            #1;
            if (kr) begin
                k_pulses++;
                k_arg = kern_init_i;
                k_cnt = k_lat;
                if (k_stale_mode && kern_w_enable) k_stale = 1;
                else kern_w_enable = 1'b0;
            end else begin
                if (k_stale) begin
                    k_stale = 0;
                    kern_w_enable = 1'b0;
                end
                if (!k_never && k_cnt > 0) begin
                    k_cnt--;
                    if (k_cnt == 0) begin
                        kern_w_enable = 1'b1;
                        kern_result   = k_arg + 64'd1;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    logic [DATA_W:0] exp_q[$];   // {timeout, data}
    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int exp_jobs = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks (called and returning at a negedge)
    // -------------------------------------------------------------------------
    task automatic send_arg(input logic [63:0] a);
        int k = 0;
        arg_valid = 1'b1;
        arg_data  = a;
        while (arg_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("arg_accept", {63'd0, arg_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        arg_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("job_finish", {63'd0, busy}, 64'd0);
    endtask

    task automatic pop_check(input string tag);
        logic [DATA_W:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_nothing_expected"}, {63'd0, res_valid}, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, {63'd0, res_valid}, 64'd1);
            chk({tag, "_data"}, res_data, e[DATA_W-1:0]);
            chk({tag, "_timeout"}, {63'd0, res_timeout}, {63'd0, e[DATA_W]});
            res_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            res_ready = 1'b0;
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] exp_cnt();
        return 64'(exp_jobs % (1 << CNT_W));
    endfunction

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic [63:0] a;
        int p0;
        r_enable = 1'b1; arg_valid = 1'b0; arg_data = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_kern_r_enable", {63'd0, kern_r_enable}, 64'd1);
        chk("rst_arg_ready", {63'd0, arg_ready}, 64'd0);
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_job_count", 64'(job_count), 64'd0);
        chk("rst_init", kern_init_i, 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        r_enable = 1'b0;
        @(negedge clk);
        chk("post_rst_arg_ready", {63'd0, arg_ready}, 64'd1);
        chk("post_rst_kern_r_enable", {63'd0, kern_r_enable}, 64'd0);

        // 1: arg 5, latency 3, cycle-exact launch and done-to-output
        k_lat = 3; k_stale_mode = 0; k_never = 0;
        p0 = k_pulses;
        send_arg(64'd5);
        chk("t1_issue_pulse", {63'd0, kern_r_enable}, 64'd1);
        chk("t1_init", kern_init_i, 64'd5);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_arg_ready_low", {63'd0, arg_ready}, 64'd0);
        @(negedge clk);
        chk("t1_guard_no_pulse", {63'd0, kern_r_enable}, 64'd0);
        repeat (3) @(negedge clk);
        chk("t1_done_seen", {63'd0, kern_w_enable}, 64'd1);
        chk("t1_not_yet_valid", {63'd0, res_valid}, 64'd0);
        @(negedge clk);
        chk("t1_res_valid", {63'd0, res_valid}, 64'd1);
        chk("t1_idle", {63'd0, busy}, 64'd0);
        chk("t1_pulses", 64'(k_pulses - p0), 64'd1);
        exp_q.push_back({1'b0, 64'd6});
        exp_jobs++;
        chk("t1_job_count", 64'(job_count), exp_cnt());
        pop_check("t1_pop");
        chk("t1_empty", {63'd0, res_valid}, 64'd0);

        // 2: stale done through ISSUE/GUARD
        k_stale_mode = 1; k_lat = 3;
        a = rnd64();
        send_arg(a);
        @(negedge clk);
        chk("t2_stale_visible", {63'd0, kern_w_enable}, 64'd1);
        @(negedge clk);
        chk("t2_no_early_capture", {63'd0, busy}, 64'd1);
        chk("t2_no_early_entry", {63'd0, res_valid}, 64'd0);
        wait_idle(30);
        exp_q.push_back({1'b0, a + 64'd1});
        exp_jobs++;
        chk("t2_job_count", 64'(job_count), exp_cnt());
        pop_check("t2_pop");
        k_stale_mode = 0;

        // 3: kernel never done -> timeout entry 16 cycles after GUARD
        k_never = 1;
        send_arg(rnd64());
        @(negedge clk);                 // GUARD
        repeat (TIMEOUT) @(negedge clk); // last WAIT cycle
        chk("t3_still_waiting", {63'd0, busy}, 64'd1);
        chk("t3_no_entry_yet", {63'd0, res_valid}, 64'd0);
        @(negedge clk);
        chk("t3_idle", {63'd0, busy}, 64'd0);
        chk("t3_arg_ready", {63'd0, arg_ready}, 64'd1);
        exp_q.push_back({1'b1, 64'd0});
        exp_jobs++;
        chk("t3_job_count", 64'(job_count), exp_cnt());
        pop_check("t3_pop");
        chk("t3_single_entry", {63'd0, res_valid}, 64'd0);
        k_never = 0;

        // 4/5: fill FIFO, 5th job stalls, pop and push in the same cycle
        res_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            k_lat = $urandom_range(1, 5);
            a = rnd64();
            send_arg(a);
            wait_idle(30);
            exp_q.push_back({1'b0, a + 64'd1});
            exp_jobs++;
        end
        chk("t4_full_job_count", 64'(job_count), exp_cnt());
        k_lat = 2;
        a = rnd64();
        send_arg(a);
        repeat (12) @(negedge clk);
        chk("t4_stalled_busy", {63'd0, busy}, 64'd1);
        chk("t4_kernel_done", {63'd0, kern_w_enable}, 64'd1);
        chk("t4_no_push", 64'(job_count), exp_cnt());
        pop_check("t4_pop0");
        chk("t4_pushed_in_pop_cycle", {63'd0, busy}, 64'd0);
        exp_q.push_back({1'b0, a + 64'd1});
        exp_jobs++;
        chk("t4_job_count", 64'(job_count), exp_cnt());
        for (int i = 0; i < DEPTH; i++) pop_check("t5_order");
        chk("t5_count_was_4", {63'd0, res_valid}, 64'd0);

        // 6: reset in WAIT with an entry in the FIFO
        k_lat = 2;
        send_arg(rnd64());
        wait_idle(30);
        chk("t6_entry_present", {63'd0, res_valid}, 64'd1);
        k_never = 1;
        send_arg(rnd64());
        repeat (4) @(negedge clk);
        chk("t6_in_wait", {63'd0, busy}, 64'd1);
        r_enable = 1'b1;
        @(negedge clk);
        chk("t6_kern_r_enable", {63'd0, kern_r_enable}, 64'd1);
        chk("t6_res_valid", {63'd0, res_valid}, 64'd0);
        chk("t6_busy", {63'd0, busy}, 64'd0);
        chk("t6_arg_ready", {63'd0, arg_ready}, 64'd0);
        chk("t6_job_count", 64'(job_count), 64'd0);
        @(negedge clk);
        r_enable = 1'b0;
        exp_q.delete();
        exp_jobs = 0;
        k_never = 0;
        @(negedge clk);
        chk("t6_after_empty", {63'd0, res_valid}, 64'd0);
        chk("t6_after_init", kern_init_i, 64'd0);
        k_lat = 3;
        a = rnd64();
        send_arg(a);
        wait_idle(30);
        exp_q.push_back({1'b0, a + 64'd1});
        exp_jobs++;
        chk("t6_new_job_count", 64'(job_count), exp_cnt());
        pop_check("t6_new_pop");

        // Randomized jobs, crossing the job_count wrap
        for (int i = 0; i < 18; i++) begin
            k_lat = $urandom_range(1, 6);
            k_stale_mode = bit'($urandom_range(0, 1));
            a = rnd64();
            send_arg(a);
            wait_idle(40);
            exp_q.push_back({1'b0, a + 64'd1});
            exp_jobs++;
            chk("rnd_job_count", 64'(job_count), exp_cnt());
            pop_check("rnd_pop");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
